guess_solver: RTL

- Automatic player for the number-guessing game: the initiator end of the guess/enter/over/under/equal interface.
- Binary-searches the hidden 8-bit value by driving a guess and pulsing enter, then samples the game's registered over/under/equal LED outputs.
- Reports success, failure or protocol error plus tries used.
- Sits beside the game top; the board wraps both for self-play demo.

---
 rtl/guess_solver_pkg.sv | 19 +
 rtl/guess_solver_dp.sv | 61 ++++++
 rtl/guess_solver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/guess_solver_pkg.sv
// rtl/guess_solver_pkg.sv - shared state, feedback encoding and defaults for the guess solver
package guess_solver_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_RELEASE,
      S_EVAL,
      S_DONE
   } state_t;

   // Feedback vector is {over, under, equal}
   localparam logic [2:0] FB_OVER  = 3'b100;
   localparam logic [2:0] FB_UNDER = 3'b010;
   localparam logic [2:0] FB_EQUAL = 3'b001;

   localparam int DEFAULT_MAX_TRIES = 7;

endpackage

// File: rtl/guess_solver_dp.sv
// rtl/guess_solver_dp.sv - search bounds, current guess and midpoint arithmetic
module guess_solver_dp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             step,
   input  logic             dir_over,
   output logic [WIDTH-1:0] guess,
   output logic             dead
);

   localparam logic [WIDTH:0] MAX_B = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] ONE_B = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] lo;
   logic [WIDTH:0] hi;
   logic [WIDTH:0] lo_nx;
   logic [WIDTH:0] hi_nx;
   logic [WIDTH:0] guess_ext;

   assign guess_ext = {1'b0, guess};

   // Candidate bounds for the current feedback direction; only committed on step
   always_comb begin
      lo_nx = lo;
      hi_nx = hi;
      if (dir_over) begin
         hi_nx = guess_ext - ONE_B;
      end else begin
         lo_nx = guess_ext + ONE_B;
      end
   end

   // The edge checks keep hi_nx/lo_nx from wrapping before the lo>hi test
   always_comb begin
      if (dir_over) begin
         dead = (guess_ext == '0) || (lo > hi_nx);
      end else begin
         dead = (guess_ext == MAX_B) || (lo_nx > hi);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo    <= '0;
         hi    <= MAX_B;
         guess <= '0;
      end else if (init) begin
         lo    <= '0;
         hi    <= MAX_B;
         guess <= WIDTH'(MAX_B >> 1);
      end else if (step) begin
         lo    <= lo_nx;
         hi    <= hi_nx;
         guess <= WIDTH'((lo_nx + hi_nx) >> 1);
      end
   end

endmodule

// File: rtl/guess_solver.sv
// rtl/guess_solver.sv - binary-search player driving the guess/enter game interface
module guess_solver
   import guess_solver_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MAX_TRIES  = DEFAULT_MAX_TRIES,
   parameter int ENTER_HOLD = 2,
   parameter int SETTLE     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_over,
   input  logic             i_under,
   input  logic             i_equal,
   output logic [WIDTH-1:0] o_guess,
   output logic             o_enter,
   output logic             o_busy,
   output logic             o_found,
   output logic             o_fail,
   output logic             o_proto_err,
   output logic [3:0]       o_tries_used,
   output logic [WIDTH-1:0] o_result
);

   state_t     state;
   logic [7:0] hold_cnt;
   logic [2:0] fb;
   logic       start_go;
   logic       step_go;
   logic       dead;
   logic       tries_out;

   assign fb        = {i_over, i_under, i_equal};
   assign start_go  = ((state == S_IDLE) || (state == S_DONE)) && i_start;
   assign tries_out = (o_tries_used == 4'(MAX_TRIES));
   assign step_go   = (state == S_EVAL) && ((fb == FB_OVER) || (fb == FB_UNDER))
                      && !dead && !tries_out;

   guess_solver_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clk      (clk),
      .reset    (reset),
      .init     (start_go),
      .step     (step_go),
      .dir_over (i_over),
      .guess    (o_guess),
      .dead     (dead)
   );

   // Enter lags the DRIVE state by one cycle so the guess is settled a full cycle first
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         o_enter      <= 1'b0;
         o_busy       <= 1'b0;
         o_found      <= 1'b0;
         o_fail       <= 1'b0;
         o_proto_err  <= 1'b0;
         o_tries_used <= '0;
         o_result     <= '0;
      end else begin
         o_enter <= (state == S_DRIVE);
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  o_found      <= 1'b0;
                  o_fail       <= 1'b0;
                  o_proto_err  <= 1'b0;
                  o_result     <= '0;
                  o_tries_used <= 4'd1;
                  o_busy       <= 1'b1;
                  hold_cnt     <= '0;
                  state        <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (hold_cnt == 8'(ENTER_HOLD - 1)) begin
                  hold_cnt <= '0;
                  state    <= (SETTLE == 0) ? S_EVAL : S_RELEASE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            S_RELEASE: begin
               if (hold_cnt == 8'(SETTLE - 1)) begin
                  hold_cnt <= '0;
                  state    <= S_EVAL;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            S_EVAL: begin
               hold_cnt <= '0;
               case (fb)
                  FB_EQUAL: begin
                     o_found  <= 1'b1;
                     o_result <= o_guess;
                     o_busy   <= 1'b0;
                     state    <= S_DONE;
                  end
                  FB_OVER, FB_UNDER: begin
                     if (dead || tries_out) begin
                        o_fail <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_DONE;
                     end else begin
                        o_tries_used <= o_tries_used + 4'd1;
                        state        <= S_DRIVE;
                     end
                  end
                  default: begin
                     o_proto_err <= 1'b1;
                     o_fail      <= 1'b1;
                     o_busy      <= 1'b0;
                     state       <= S_DONE;
                  end
               endcase
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
